// File: rtl/prng_ctrl_pkg.sv
// Shared definitions for the PRNG sharing controller: FSM encoding, default seed
// and the LCG constants of the generator it fronts.
package prng_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_WAIT,
        ST_IDLE,
        ST_STREAM
    } state_e;

    localparam logic [7:0] DEFAULT_SEED = 8'h01;

    localparam int LCG_A = 5;
    localparam int LCG_C = 1;
    localparam int LCG_M = 256;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request scanning upward from ptr_i,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/prng_arbiter.sv
// Shares one free-running LCG PRNG between NUM_REQ requesters: owns seeding and
// streams bursts of consecutive PRNG terms to round-robin winners.
module prng_arbiter
    import prng_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 4,
    parameter int N       = 8,
    parameter logic [N-1:0] DEFAULT_SEED = N'(prng_ctrl_pkg::DEFAULT_SEED),
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     seed_valid,
    input  logic [N-1:0]             seed_in,
    output logic                     seed_ready,
    output logic                     prng_load_seed,
    output logic [N-1:0]             prng_seed_data,
    input  logic [N-1:0]             prng_data,
    input  logic                     prng_done,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [N-1:0]             rsp_data,
    output logic                     rsp_last,
    output logic                     busy
);

    state_e               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [N-1:0]         seed_q, seed_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 seed_ready_q, seed_ready_d;
    logic                 load_q, load_d;
    logic [N-1:0]         seed_data_q, seed_data_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [N-1:0]         rsp_data_q, rsp_data_d;
    logic                 rsp_last_q, rsp_last_d;
    logic                 busy_q;

    logic [NUM_REQ-1:0]   gnt;
    logic [ID_W-1:0]      gnt_idx;
    logic                 gnt_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        seed_d       = seed_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        req_ready_d  = '0;
        seed_ready_d = 1'b0;
        load_d       = 1'b0;
        seed_data_d  = seed_data_q;
        rsp_valid_d  = 1'b0;
        rsp_last_d   = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            ST_LOAD: begin
                load_d      = 1'b1;
                seed_data_d = seed_q;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // prng_done seen while our load pulse is still on the wire is stale
                if (!load_q && prng_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (seed_valid) begin
                    seed_ready_d = 1'b1;
                    seed_d       = seed_in;
                    state_d      = ST_LOAD;
                end else if (gnt_any) begin
                    req_ready_d = gnt;
                    id_d        = gnt_idx;
                    cnt_d       = req_len[int'(gnt_idx)*LEN_W +: LEN_W];
                    state_d     = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (prng_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = prng_data;
                    rsp_id_d    = id_q;
                    if (cnt_q == '0) begin
                        rsp_last_d = 1'b1;
                        rr_ptr_d   = (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + ID_W'(1);
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_LOAD;
            rr_ptr_q     <= '0;
            seed_q       <= DEFAULT_SEED;
            id_q         <= '0;
            cnt_q        <= '0;
            req_ready_q  <= '0;
            seed_ready_q <= 1'b0;
            load_q       <= 1'b0;
            seed_data_q  <= DEFAULT_SEED;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_last_q   <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            seed_q       <= seed_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            seed_ready_q <= seed_ready_d;
            load_q       <= load_d;
            seed_data_q  <= seed_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_last_q   <= rsp_last_d;
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign req_ready      = req_ready_q;
    assign seed_ready     = seed_ready_q;
    assign prng_load_seed = load_q;
    assign prng_seed_data = seed_data_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = rsp_id_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_last       = rsp_last_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_prng_arbiter.sv
// Bench for prng_arbiter: a behavioural LCG stands in for the PRNG, grants push
// expected beats to a scoreboard that rsp beats are checked against.
module tb_prng_arbiter;
    import prng_ctrl_pkg::*;

    localparam int NR = 4;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*LW-1:0] req_len = '0;
    logic [NR-1:0]   req_ready;
    logic            seed_valid = 1'b0;
    logic [7:0]      seed_in = '0;
    logic            seed_ready;
    logic            prng_load_seed;
    logic [7:0]      prng_seed_data;
    logic [7:0]      prng_data;
    logic            prng_done;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [7:0]      rsp_data;
    logic            rsp_last;
    logic            busy;

    prng_arbiter #(.NUM_REQ(NR), .LEN_W(LW), .N(8), .DEFAULT_SEED(8'h01)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
        .seed_valid(seed_valid), .seed_in(seed_in), .seed_ready(seed_ready),
        .prng_load_seed(prng_load_seed), .prng_seed_data(prng_seed_data),
        .prng_data(prng_data), .prng_done(prng_done),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural PRNG: load takes the seed with done low, otherwise x <- 5x+1 mod 256.
    logic [7:0] pm_state = 8'h3C;
    logic       pm_done  = 1'b1;
    assign prng_data = pm_state;
    assign prng_done = pm_done;

    function automatic logic [7:0] lcg(logic [7:0] x);
        return 8'((LCG_A * int'(x) + LCG_C) % LCG_M);
    endfunction

    always @(posedge clk) begin
        if (prng_load_seed) begin
            pm_state <= prng_seed_data;
            pm_done  <= 1'b0;
        end else begin
            pm_state <= lcg(pm_state);
            pm_done  <= 1'b1;
        end
    end

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        int id;
        int len;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    beat_t sb[$];
    int grant_idx[$];
    int grant_cyc[$];
    int n_seed_rdy = 0;
    int seed_rdy_cyc = 0;
    int n_load = 0;
    logic [7:0] last_load_data = '0;
    int beats = 0;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: grants feed the scoreboard, rsp beats drain it.
    always @(negedge clk) begin
        if (prng_load_seed) begin
            n_load++;
            last_load_data = prng_seed_data;
        end
        if (reset) begin
            if (rsp_valid) begin
                beats++;
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("rsp_id", int'(rsp_id), e.id);
                    chk("rsp_data", int'(rsp_data), int'(e.data));
                    chk("rsp_last", int'(rsp_last), int'(e.last));
                end
            end
            if (seed_ready) begin
                n_seed_rdy++;
                seed_rdy_cyc = cyc;
            end
            if (req_ready != '0) begin
                int idx;
                int len;
                logic [7:0] d;
                idx = 0;
                chk("req_ready_onehot", $countones(req_ready), 1);
                for (int i = 0; i < NR; i++) if (req_ready[i]) idx = i;
                len = int'(req_len[idx*LW +: LW]);
                d = pm_state;
                for (int k = 0; k <= len; k++) begin
                    beat_t e;
                    e.id = idx;
                    e.data = d;
                    e.last = (k == len);
                    sb.push_back(e);
                    d = lcg(d);
                end
                grant_idx.push_back(idx);
                grant_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(string nm);
        int k = 0;
        while (busy !== 1'b0 && k < 300) begin tick(); k++; end
        chk(nm, int'(busy), 0);
    endtask

    task automatic wait_grants(int n, string nm);
        int k = 0;
        while (grant_idx.size() < n && k < 300) begin tick(); k++; end
        chk(nm, grant_idx.size(), n);
    endtask

    task automatic wait_drain(string nm);
        int k = 0;
        while (sb.size() != 0 && k < 300) begin tick(); k++; end
        chk(nm, sb.size(), 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_seed_ready", int'(seed_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_last", int'(rsp_last), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_load_seed", int'(prng_load_seed), 0);
        chk("rst_seed_data", int'(prng_seed_data), 8'h01);
        chk("rst_busy", int'(busy), 1);
    endtask

    vec_t tbl[5];
    int exp_rr[5];

    initial begin
        int k;
        logic done_ok;

        tbl[0] = '{0, 3};
        tbl[1] = '{1, 0};
        tbl[2] = '{2, 7};
        tbl[3] = '{1, 1};
        tbl[4] = '{3, 15};
        exp_rr = '{0, 1, 2, 3, 0};

        // Power-on: reset values, single load of the default seed, idle only after done.
        repeat (3) tick();
        chk_reset_vals();
        n_load = 0;
        reset = 1'b1;
        done_ok = 1'b0;
        k = 0;
        while (k < 30) begin
            tick();
            k++;
            if (busy === 1'b0) break;
            if (n_load >= 1 && !prng_load_seed && prng_done) done_ok = 1'b1;
        end
        chk("por_idle", int'(busy), 0);
        chk("por_load_pulses", n_load, 1);
        chk("por_load_data", int'(last_load_data), 8'h01);
        chk("por_busy_after_done", int'(done_ok), 1);

        // Reseed with 0, then the table of single-requester bursts.
        n_load = 0;
        n_seed_rdy = 0;
        seed_in = 8'h00;
        seed_valid = 1'b1;
        k = 0;
        while (n_seed_rdy == 0 && k < 50) begin tick(); k++; end
        seed_valid = 1'b0;
        chk("seed0_ready", n_seed_rdy, 1);
        wait_idle("seed0_idle");
        chk("seed0_load_pulses", n_load, 1);
        chk("seed0_load_data", int'(last_load_data), 8'h00);

        for (int t = 0; t < 5; t++) begin
            grant_idx.delete();
            grant_cyc.delete();
            req_len = '0;
            req_len[tbl[t].id*LW +: LW] = LW'(tbl[t].len);
            req_valid[tbl[t].id] = 1'b1;
            wait_grants(1, "tbl_grant");
            req_valid = '0;
            if (grant_idx.size() > 0) chk("tbl_grant_id", grant_idx[0], tbl[t].id);
            wait_drain("tbl_drain");
            wait_idle("tbl_idle");
        end

        // All requesters with single-byte bursts: round-robin order and one idle gap.
        grant_idx.delete();
        grant_cyc.delete();
        req_len = '0;
        req_valid = '1;
        wait_grants(5, "rr_grants");
        req_valid = '0;
        wait_drain("rr_drain");
        wait_idle("rr_idle");
        for (int i = 0; i < 5; i++)
            if (i < grant_idx.size()) chk("rr_order", grant_idx[i], exp_rr[i]);
        for (int i = 0; i < 4; i++)
            if (i + 1 < grant_cyc.size()) chk("rr_spacing", grant_cyc[i+1] - grant_cyc[i], 2);

        // Seed request arriving mid-burst waits for all 16 beats.
        grant_idx.delete();
        grant_cyc.delete();
        req_len = '0;
        req_len[2*LW +: LW] = 4'hF;
        req_valid[2] = 1'b1;
        wait_grants(1, "pre_grant");
        req_valid = '0;
        beats = 0;
        n_seed_rdy = 0;
        n_load = 0;
        repeat (3) tick();
        seed_in = 8'hA5;
        seed_valid = 1'b1;
        k = 0;
        while (n_seed_rdy == 0 && k < 60) begin tick(); k++; end
        seed_valid = 1'b0;
        chk("pre_seed_ready", n_seed_rdy, 1);
        chk("pre_beats_before_seed", beats, 16);
        wait_idle("pre_idle");
        chk("pre_load_pulses", n_load, 1);
        chk("pre_load_data", int'(last_load_data), 8'hA5);
        wait_drain("pre_drain");

        // Seed and request in the same idle cycle: seed wins.
        grant_idx.delete();
        grant_cyc.delete();
        n_seed_rdy = 0;
        req_len = '0;
        req_len[1*LW +: LW] = 4'd2;
        seed_in = 8'h5A;
        seed_valid = 1'b1;
        req_valid[1] = 1'b1;
        k = 0;
        while (grant_idx.size() == 0 && k < 60) begin
            tick();
            k++;
            if (n_seed_rdy > 0) seed_valid = 1'b0;
        end
        req_valid = '0;
        seed_valid = 1'b0;
        chk("simul_grant_seen", grant_idx.size(), 1);
        if (grant_idx.size() > 0) begin
            chk("simul_grant_id", grant_idx[0], 1);
            chk("simul_seed_first", int'(n_seed_rdy == 1 && seed_rdy_cyc < grant_cyc[0]), 1);
        end
        wait_drain("simul_drain");
        wait_idle("simul_idle");

        // Reset on beat 3 of a 5-beat burst.
        grant_idx.delete();
        grant_cyc.delete();
        req_len = '0;
        req_len[0 +: LW] = 4'd4;
        req_valid[0] = 1'b1;
        wait_grants(1, "rst_grant");
        req_valid = '0;
        beats = 0;
        k = 0;
        while (beats < 3 && k < 30) begin tick(); k++; end
        chk("rst_beat3_reached", beats, 3);
        reset = 1'b0;
        tick();
        sb.delete();
        chk_reset_vals();
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_hold_last", int'(rsp_last), 0);
            chk("rst_hold_ready", int'(req_ready), 0);
        end
        n_load = 0;
        reset = 1'b1;
        wait_idle("rst_idle");
        chk("rst_load_pulses", n_load, 1);
        chk("rst_load_default", int'(last_load_data), 8'h01);

        grant_idx.delete();
        grant_cyc.delete();
        req_len = '0;
        req_len[3*LW +: LW] = 4'd1;
        req_valid[3] = 1'b1;
        wait_grants(1, "post_grant");
        req_valid = '0;
        if (grant_idx.size() > 0) chk("post_grant_id", grant_idx[0], 3);
        wait_drain("post_drain");
        wait_idle("post_idle");
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
